// File: rtl/pla_pkg.sv
// pla_pkg: shared state encoding, control-word layout and control-store indexing for the sequencer arbiter
package pla_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int ALU_SEL_LSB = 0;
  localparam int ALU_SEL_W = 2;
  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD = 2'd1;
  localparam logic [1:0] ALU_SUB = 2'd2;
  localparam logic [1:0] ALU_CMP = 2'd3;
  function automatic int end_bit(input int cw);
    return cw - 1;
  endfunction
  function automatic int ucode_off(input int c, input int s, input int steps, input int cw);
    return (c * steps + s) * cw;
  endfunction
endpackage

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: one-hot winner among requests, fixed priority or round-robin from ptr
module rr_arbiter_n #(
  parameter int N_CH = 3,
  parameter int PW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            mode,
  output logic [N_CH-1:0] win
);
  logic [PW-1:0] idx;
  logic found;
  // cyclic scan starting at ptr in round-robin mode, at 0 in fixed mode
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      idx = mode ? PW'((int'(ptr) + i) % N_CH) : PW'(i);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pla_sequencer_arb.sv
// pla_sequencer_arb: arbitrates channel requests and plays the winner's one-hot microsequence
module pla_sequencer_arb
  import pla_pkg::*;
#(
  parameter int N_CH = 3,
  parameter int STEPS = 4,
  parameter int CW = 8,
  parameter int RR = 1
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH-1:0]          stall,
  input  logic [N_CH*STEPS*CW-1:0] ucode,
  output logic [N_CH-1:0]          grant,
  output logic [STEPS-1:0]         step,
  output logic [CW-1:0]            ctrl,
  output logic [ALU_SEL_W-1:0]     alu_sel,
  output logic                     busy,
  output logic                     done
);
  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int END_BIT = end_bit(CW);
  state_t state, state_n;
  logic [N_CH-1:0] grant_n, win;
  logic [STEPS-1:0] step_n;
  logic [PW-1:0] rr_ptr, ptr_n, win_idx;
  logic [CW-1:0] word;
  rr_arbiter_n #(.N_CH(N_CH)) u_arb (
    .req(req),
    .ptr(rr_ptr),
    .mode(RR != 0),
    .win(win)
  );
  // select the control word of the granted channel at the current step; encode the winner
  always_comb begin
    word = '0;
    win_idx = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (win[c]) win_idx = PW'(c);
      for (int s = 0; s < STEPS; s++)
        if (grant[c] && step[s]) word = ucode[ucode_off(c, s, STEPS, CW) +: CW];
    end
  end
  // next state: grant from IDLE, step or hold in RUN, one DONE cycle back to IDLE
  always_comb begin
    state_n = state;
    grant_n = grant;
    step_n = step;
    ptr_n = rr_ptr;
    unique case (state)
      IDLE: if (|req) begin
        state_n = RUN;
        grant_n = win;
        step_n = STEPS'(1);
        ptr_n = (win_idx == PW'(N_CH - 1)) ? '0 : win_idx + 1'b1;
      end
      RUN: if (!(|(stall & grant))) begin
        if (word[END_BIT] || step[STEPS-1]) state_n = DONE;
        else step_n = step << 1;
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        step_n = STEPS'(1);
      end
    endcase
  end
  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
      grant <= '0;
      step <= STEPS'(1);
      rr_ptr <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      step <= step_n;
      rr_ptr <= ptr_n;
    end
  end
  assign ctrl = (state == RUN) ? word : '0;
  assign alu_sel = ctrl[ALU_SEL_LSB +: ALU_SEL_W];
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_pla_sequencer_arb.sv
// tb_pla_sequencer_arb: scoreboard bench for the sequencer arbiter (round-robin and fixed-priority instances)
module tb_pla_sequencer_arb;
  typedef struct {
    logic [2:0] g;
    logic [3:0] s;
    logic [7:0] c;
    logic d;
  } exp_t;
  logic clk = 1'b0;
  logic clear;
  logic [2:0] req, stall;
  logic [95:0] ucode;
  logic [2:0] grant, f_grant;
  logic [3:0] step, f_step;
  logic [7:0] ctrl, f_ctrl;
  logic [1:0] alu_sel, f_alu_sel;
  logic busy, done, f_busy, f_done;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  logic prev_done = 1'b0;
  pla_sequencer_arb #(.N_CH(3), .STEPS(4), .CW(8), .RR(1)) dut (
    .clk(clk), .clear(clear), .req(req), .stall(stall), .ucode(ucode),
    .grant(grant), .step(step), .ctrl(ctrl), .alu_sel(alu_sel), .busy(busy), .done(done)
  );
  pla_sequencer_arb #(.N_CH(3), .STEPS(4), .CW(8), .RR(0)) dut_fx (
    .clk(clk), .clear(clear), .req(req), .stall(stall), .ucode(ucode),
    .grant(f_grant), .step(f_step), .ctrl(f_ctrl), .alu_sel(f_alu_sel), .busy(f_busy), .done(f_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic ps(input logic [2:0] g, input logic [3:0] s, input logic [7:0] c, input logic d);
    exp_t e;
    e.g = g; e.s = s; e.c = c; e.d = d;
    q.push_back(e);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 30) chk({name, "_timeout"}, 0, 1);
  endtask
  task automatic chk_idle(input string name);
    chk({name, "_grant"}, 32'(grant), 0);
    chk({name, "_step"}, 32'(step), 1);
    chk({name, "_busy"}, 32'(busy), 0);
  endtask
  // monitor: every busy cycle of the round-robin DUT consumes one expected entry
  always @(negedge clk) begin
    exp_t e;
    if (!clear) prev_done = 1'b0;
    else begin
      if (prev_done) chk("idle_gap", 32'(busy), 0);
      if (busy) begin
        if (q.size() == 0) chk("unexpected_busy", 32'(step), 0);
        else begin
          e = q.pop_front();
          chk("grant", 32'(grant), 32'(e.g));
          chk("step", 32'(step), 32'(e.s));
          chk("ctrl", 32'(ctrl), 32'(e.c));
          chk("alu_sel", 32'(alu_sel), 32'(e.c[1:0]));
          chk("done", 32'(done), 32'(e.d));
        end
      end
      prev_done = done;
    end
  end
  initial begin
    int nd;
    clear = 1'b0; req = '0; stall = '0;
    ucode = '0;
    ucode[0 +: 8] = 8'h01; ucode[8 +: 8] = 8'h02; ucode[16 +: 8] = 8'h83;
    ucode[32 +: 8] = 8'h11; ucode[40 +: 8] = 8'h12; ucode[48 +: 8] = 8'h93;
    repeat (2) cyc();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_step", 32'(step), 1);
    chk("rst_ctrl", 32'(ctrl), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    clear = 1'b1;
    cyc();
    // single channel 0
    ps(3'b001, 4'b0001, 8'h01, 0); ps(3'b001, 4'b0010, 8'h02, 0);
    ps(3'b001, 4'b0100, 8'h83, 0); ps(3'b001, 4'b0100, 8'h00, 1);
    req = 3'b001;
    cyc();
    req = '0;
    wait_done("single");
    cyc();
    chk_idle("single_idle");
    // round robin from a fresh pointer, fixed-priority instance watched alongside
    clear = 1'b0;
    cyc();
    clear = 1'b1;
    cyc();
    ps(3'b001, 4'b0001, 8'h01, 0); ps(3'b001, 4'b0010, 8'h02, 0);
    ps(3'b001, 4'b0100, 8'h83, 0); ps(3'b001, 4'b0100, 8'h00, 1);
    ps(3'b010, 4'b0001, 8'h11, 0); ps(3'b010, 4'b0010, 8'h12, 0);
    ps(3'b010, 4'b0100, 8'h93, 0); ps(3'b010, 4'b0100, 8'h00, 1);
    ps(3'b100, 4'b0001, 8'h00, 0); ps(3'b100, 4'b0010, 8'h00, 0);
    ps(3'b100, 4'b0100, 8'h00, 0); ps(3'b100, 4'b1000, 8'h00, 0);
    ps(3'b100, 4'b1000, 8'h00, 1);
    ps(3'b001, 4'b0001, 8'h01, 0); ps(3'b001, 4'b0010, 8'h02, 0);
    ps(3'b001, 4'b0100, 8'h83, 0); ps(3'b001, 4'b0100, 8'h00, 1);
    req = 3'b111;
    nd = 0;
    for (int k = 0; k < 80 && nd < 4; k++) begin
      @(negedge clk);
      if (f_grant != 0) chk("fixed_grant", 32'(f_grant), 32'b001);
      if (done) nd++;
    end
    if (nd < 4) chk("rr_timeout", 32'(nd), 4);
    req = '0;
    cyc();
    cyc();
    chk_idle("rr_idle");
    repeat (6) cyc();
    // stall on channel 1 at step 0010; stall on channel 0 ignored
    ps(3'b010, 4'b0001, 8'h11, 0); ps(3'b010, 4'b0010, 8'h12, 0);
    ps(3'b010, 4'b0010, 8'h12, 0); ps(3'b010, 4'b0010, 8'h12, 0);
    ps(3'b010, 4'b0100, 8'h93, 0); ps(3'b010, 4'b0100, 8'h00, 1);
    req = 3'b010;
    cyc();
    req = '0;
    cyc();
    stall = 3'b010;
    cyc();
    cyc();
    stall = 3'b001;
    cyc();
    stall = '0;
    wait_done("stall");
    cyc();
    chk_idle("stall_idle");
    // channel 2 has no END bit: runs all four steps
    ps(3'b100, 4'b0001, 8'h00, 0); ps(3'b100, 4'b0010, 8'h00, 0);
    ps(3'b100, 4'b0100, 8'h00, 0); ps(3'b100, 4'b1000, 8'h00, 0);
    ps(3'b100, 4'b1000, 8'h00, 1);
    req = 3'b100;
    cyc();
    req = '0;
    wait_done("noend");
    cyc();
    chk_idle("noend_idle");
    // asynchronous clear at step 0100 aborts without done
    ps(3'b001, 4'b0001, 8'h01, 0); ps(3'b001, 4'b0010, 8'h02, 0);
    ps(3'b001, 4'b0100, 8'h83, 0);
    req = 3'b001;
    cyc();
    req = '0;
    cyc();
    @(posedge clk);
    @(negedge clk);
    #1 clear = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 0);
    chk("arst_step", 32'(step), 1);
    chk("arst_ctrl", 32'(ctrl), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    cyc();
    clear = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("arst_nodone", 32'({busy, done}), 0);
    end
    chk("queue_empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pla_sequencer_arb.md
Name: pla_sequencer_arb

Overview:
- N-channel micro-sequencer arbiter; parametrised successor to the fixed three-controller arrangement (timer set / time update / timer compare) with its status arbiter and ALU-select mux.
- Arbitrates among channel requests and runs the granted channel's one-hot microsequence.
- Drives one control word per cycle, including the ALU select, until that channel finishes.
- Sits between the clock's mode/condition logic and the datapath (ALU, register load/enable strobes).

Parameters:
- N_CH, 3: number of requesting channels.
- STEPS, 4: maximum microsequence length; width of the one-hot step register.
- CW, 8: control word width. Bit CW-1 is END; bits [1:0] are the ALU select.
- RR, 1: 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clear  in  1  reset, asynchronous, active-low (0 = reset).
- req  in  N_CH  level request per channel.
- stall  in  N_CH  per-channel wait condition; holds the current step of the granted channel.
- ucode  in  N_CH*STEPS*CW  flattened control store. Word (c,s) sits at bits [(c*STEPS+s)*CW +: CW].
- grant  out  N_CH  one-hot granted channel; 0 when idle.
- step  out  STEPS  one-hot current step; STEPS'b1 when idle.
- ctrl  out  CW  current control word; 0 outside RUN.
- alu_sel  out  2  equal to ctrl[1:0].
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse in the DONE state.

Behaviour:
- Reset (clear=0, asynchronous, effective immediately):
  - state=IDLE, grant=0, step=1, ctrl=0, busy=0, done=0.
  - Round-robin pointer = 0.
  - Reset mid-RUN aborts the sequence with no done pulse.
- FSM states: IDLE, RUN, DONE. Registered state, grant, step and rr_ptr; ctrl, alu_sel, busy and done decode combinationally from those registers.
- IDLE:
  - If any req bit is set, latch the grant and set step=1 (first step) on the next edge, then go to RUN.
  - Latency: req visible in cycle N gives grant and ctrl = word(c,0) in cycle N+1.
  - With no request, remain in IDLE.
- Arbitration:
  - RR=0: lowest set index wins.
  - RR=1: first set bit at or after rr_ptr, searching cyclically (wrap N_CH-1 -> 0).
  - rr_ptr updates to (granted+1) mod N_CH when the channel is granted.
- RUN:
  - ctrl = word(granted channel, index of step).
  - If stall[granted]=1, step and ctrl hold.
  - Otherwise, if ctrl[CW-1]=1 or step[STEPS-1]=1, go to DONE. Otherwise shift step left by one.
  - Requests from any channel during RUN are ignored; they must remain asserted to be served later.
  - Dropping req of the granted channel mid-sequence does not abort it.
  - stall on non-granted channels is ignored.
- DONE (exactly one cycle):
  - done=1, busy=1, ctrl=0, grant still shows the finishing channel.
  - Next edge: grant=0, step=1, go to IDLE.
  - No back-to-back grant; at least one IDLE cycle separates sequences.
- A stall asserted in the same cycle as END takes priority: hold in RUN until the stall drops.
- A sequence takes (number of non-stalled steps) + (stall cycles) RUN cycles, then 1 DONE cycle and 1 IDLE cycle.

Decomposition:
- Shared package (pla_pkg):
  - FSM state enum {IDLE, RUN, DONE}.
  - Constants END_BIT = CW-1, ALU_SEL_LSB = 0, ALU_SEL_W = 2.
  - ucode index function (channel, step) -> bit offset.
  - ALU select encodings shared with alu_control_signal.
- One sub-module: rr_arbiter_n. Inputs req, ptr, mode; output one-hot win. Purely combinational. Parametrised by N_CH; handles both fixed and round-robin modes.

Test Plan (N_CH=3, STEPS=4, CW=8):
- Single channel: req=001 with ch0 words 0x01, 0x02, 0x83.
  - grant=001 the next cycle.
  - ctrl 0x01, 0x02, 0x83 over three cycles; alu_sel 1, 2, 3.
  - Then done=1 and ctrl=0 for one cycle; then grant=0, step=0001.
- Round-robin: RR=1, req=111 held.
  - Grants in order 001, 010, 100, 001.
  - Each sequence is separated by DONE plus one IDLE cycle.
- Fixed priority: RR=0, req=111 held. Every sequence is granted to ch0 (grant=001).
- Stall: ch1 granted, stall=010 for 2 cycles at step 0010.
  - step and ctrl hold for 2 cycles, then advance.
  - stall=001 meanwhile has no effect.
- No END bit: all ch2 words 0x00 gives 4 RUN cycles (step 0001 -> 1000), then DONE.
- Reset and request drop:
  - clear=0 asynchronously at step 0100: outputs are at reset values before the next edge, with no done pulse.
  - Separately, dropping req mid-RUN still completes the sequence with done=1.
